// File: rtl/a2d_scan_intf_if.sv
// SPI pin bundle between the ADC128S-style converter and its scanning master.
interface a2d_scan_intf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_scan_intf.sv
// Pipelined multi-slot scanner for an ADC128S-style 12-bit SPI converter.
// Define A2D_AVG_EN to replace raw per-slot updates with a (3*old + new)/4 filter.
module a2d_scan_intf #(
    parameter int          NUM_CH      = 4,
    parameter logic [23:0] CH_MAP      = 24'o76543210,
    parameter int          SCLK_DIV    = 32,
    parameter int          SCAN_PERIOD = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trig,
    a2d_scan_intf_if.master       spi,
    output logic [12*NUM_CH-1:0]  data,
    output logic                  scan_done,
    output logic                  busy
);

    localparam int              CW        = $clog2(SCLK_DIV);
    localparam logic [CW-1:0]   H_LAST    = CW'(SCLK_DIV / 2 - 1);
    localparam int              PW        = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [PW-1:0]   P_LAST    = PW'((SCAN_PERIOD > 0) ? SCAN_PERIOD - 1 : 0);
    localparam logic [PW-1:0]   P_RESTART = (SCAN_PERIOD > 1) ? PW'(1) : PW'(0);
    localparam logic [3:0]      F_LAST    = 4'(NUM_CH);

    typedef enum logic [2:0] {IDLE, PORCH, SHIFT, BACK, GAP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_cnt;
    logic [3:0]      frame;
    logic [15:0]     tx;
    logic [11:0]     rx;
    logic [PW-1:0]   period_cnt;
    logic            pending;
    logic            period_hit;
    logic            ss_n_q;
    logic            sclk_q;
    logic            mosi_q;
`ifdef A2D_AVG_EN
    logic [NUM_CH-1:0] seen;
`endif

    assign spi.SS_n = ss_n_q;
    assign spi.SCLK = sclk_q;
    assign spi.MOSI = mosi_q;

    assign period_hit = (SCAN_PERIOD > 0) && (period_cnt == '0);

    // The frame after the last slot re-addresses slot 0 purely to clock out the final result.
    function automatic logic [15:0] cmd_for(input logic [3:0] f);
        logic [2:0] ch;
        ch = CH_MAP[2:0];
        for (int k = 0; k < NUM_CH; k++) begin
            if (f == 4'(k)) ch = CH_MAP[3*k +: 3];
        end
        return {2'b00, ch, 11'h000};
    endfunction

`ifdef A2D_AVG_EN
    function automatic logic [11:0] avg12(input logic [11:0] old, input logic [11:0] raw);
        return 12'(({2'b00, old} + {1'b0, old, 1'b0} + {2'b00, raw}) >> 2);
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            tx         <= '0;
            rx         <= '0;
            period_cnt <= '0;
            pending    <= 1'b0;
            ss_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            data       <= '0;
            scan_done  <= 1'b0;
            busy       <= 1'b0;
`ifdef A2D_AVG_EN
            seen       <= '0;
`endif
        end else begin
            scan_done <= 1'b0;
            if (SCAN_PERIOD > 0)
                period_cnt <= (period_cnt == P_LAST) ? '0 : period_cnt + 1'b1;
            if (period_hit && state != IDLE)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (trig || pending || period_hit) begin
                        state      <= PORCH;
                        busy       <= 1'b1;
                        ss_n_q     <= 1'b0;
                        cnt        <= '0;
                        frame      <= '0;
                        tx         <= cmd_for(4'd0);
                        pending    <= 1'b0;
                        period_cnt <= P_RESTART;
                    end
                end
                PORCH: begin
                    if (cnt == H_LAST) begin
                        state   <= SHIFT;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        sclk_q  <= 1'b0;
                        mosi_q  <= tx[15];
                        tx      <= {tx[14:0], 1'b0};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Each half-period lasts H cycles; MISO is captured on the edge that raises SCLK.
                SHIFT: begin
                    if (cnt == H_LAST) begin
                        cnt <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx     <= {rx[10:0], spi.MISO};
                        end else if (bit_cnt == 4'd15) begin
                            state <= BACK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sclk_q  <= 1'b0;
                            mosi_q  <= tx[15];
                            tx      <= {tx[14:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BACK: begin
                    if (cnt == H_LAST) begin
                        state  <= GAP;
                        cnt    <= '0;
                        ss_n_q <= 1'b1;
                        mosi_q <= 1'b0;
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (frame == 4'(k + 1)) begin
`ifdef A2D_AVG_EN
                                data[12*k +: 12] <= seen[k] ? avg12(data[12*k +: 12], rx) : rx;
                                seen[k]          <= 1'b1;
`else
                                data[12*k +: 12] <= rx;
`endif
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CW'(1)) begin
                        cnt <= '0;
                        if (frame == F_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state  <= PORCH;
                            frame  <= frame + 4'd1;
                            ss_n_q <= 1'b0;
                            tx     <= cmd_for(frame + 4'd1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (frame == F_LAST) scan_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
